// File: rtl/wake_vote.sv
// wake_vote: keyword-spotting wake decision with majority vote and holdoff.
//
// Each accepted beat carries NUM_CLASSES signed scores. The beat's argmax
// class is found, a wake vote (argmax == WAKE_CLASS) is shifted into a
// WINDOW-deep history, and a wake fires when at least VOTES of the history
// bits are set and no holdoff is active. A fire clears the history and loads
// a holdoff down-counter that suppresses the next HOLDOFF accepted beats.
//
// Ports:
//   clk_i    - clock
//   rst_n_i  - asynchronous active-low reset
//   data_i   - packed scores, class k at [k*I_BW +: I_BW]
//   valid_i  - input beat valid
//   last_i   - last beat of a session; vote state clears after it
//   ready_o  - input ready (!valid_o || ready_i)
//   class_o  - argmax class of the beat (lowest index wins ties)
//   wake_o   - wake decision of the beat
//   last_o   - registered last_i
//   valid_o  - output beat valid
//   ready_i  - downstream ready
module wake_vote #(
  parameter int I_BW        = 32,
  parameter int NUM_CLASSES = 2,
  parameter int WAKE_CLASS  = 1,
  parameter int WINDOW      = 4,
  parameter int VOTES       = 3,
  parameter int HOLDOFF     = 2,
  localparam int CW         = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [NUM_CLASSES*I_BW-1:0] data_i,
  input  logic                        valid_i,
  input  logic                        last_i,
  output logic                        ready_o,
  output logic [CW-1:0]               class_o,
  output logic                        wake_o,
  output logic                        last_o,
  output logic                        valid_o,
  input  logic                        ready_i
);

  localparam int CNTW = $clog2(WINDOW + 1);
  localparam logic [CW-1:0]   WAKE_C  = CW'(WAKE_CLASS);
  localparam logic [CNTW-1:0] VOTES_C = CNTW'(VOTES);
  localparam logic [7:0]      HOLD_C  = 8'(HOLDOFF);

  logic              valid_q, valid_d;
  logic [CW-1:0]     class_q, class_d;
  logic              wake_q, wake_d;
  logic              last_q, last_d;
  logic [WINDOW-1:0] hist_q, hist_d;
  logic [7:0]        hold_q, hold_d;

  logic                   accept;
  logic [CW-1:0]          best_idx;
  logic signed [I_BW-1:0] best_val;
  logic [WINDOW-1:0]      hist_upd;
  logic [CNTW-1:0]        vote_cnt;
  logic                   fire;

  assign ready_o = !valid_q || ready_i;
  assign accept  = valid_i && ready_o;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = $signed(data_i[0 +: I_BW]);
    for (int k = 1; k < NUM_CLASSES; k++) begin
      if ($signed(data_i[k*I_BW +: I_BW]) > best_val) begin
        best_val = $signed(data_i[k*I_BW +: I_BW]);
        best_idx = CW'(k);
      end
    end
  end

  always_comb begin
    hist_upd    = hist_q << 1;
    hist_upd[0] = (best_idx == WAKE_C);
    vote_cnt    = '0;
    for (int i = 0; i < WINDOW; i++) begin
      vote_cnt = vote_cnt + CNTW'(hist_upd[i]);
    end
    fire = (vote_cnt >= VOTES_C) && (hold_q == 8'd0);
  end

  always_comb begin
    valid_d = valid_q;
    class_d = class_q;
    wake_d  = wake_q;
    last_d  = last_q;
    hist_d  = hist_q;
    hold_d  = hold_q;
    if (accept) begin
      valid_d = 1'b1;
      class_d = best_idx;
      wake_d  = fire;
      last_d  = last_i;
      if (hold_q != 8'd0) begin
        // Suppressed beats cast no vote, so a fresh run of VOTES wake
        // beats is needed once the holdoff expires.
        hold_d = hold_q - 8'd1;
      end else if (fire) begin
        hist_d = '0;
        hold_d = HOLD_C;
      end else begin
        hist_d = hist_upd;
      end
      if (last_i) begin
        hist_d = '0;
        hold_d = 8'd0;
      end
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      class_q <= '0;
      wake_q  <= 1'b0;
      last_q  <= 1'b0;
      hist_q  <= '0;
      hold_q  <= 8'd0;
    end else begin
      valid_q <= valid_d;
      class_q <= class_d;
      wake_q  <= wake_d;
      last_q  <= last_d;
      hist_q  <= hist_d;
      hold_q  <= hold_d;
    end
  end

  assign valid_o = valid_q;
  assign class_o = class_q;
  assign wake_o  = wake_q;
  assign last_o  = last_q;

endmodule

// File: tb/tb_wake_vote.sv
// tb_wake_vote: directed-vector bench for wake_vote at default parameters.
module tb_wake_vote;

  logic        clk_i;
  logic        rst_n_i;
  logic [63:0] data_i;
  logic        valid_i;
  logic        last_i;
  logic        ready_o;
  logic        class_o;
  logic        wake_o;
  logic        last_o;
  logic        valid_o;
  logic        ready_i;

  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;
  int out0;

  wake_vote dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .ready_o (ready_o),
    .class_o (class_o),
    .wake_o  (wake_o),
    .last_o  (last_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (valid_o && ready_i) n_out++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int c0, input int c1, input logic lst);
    data_i  = {c1[31:0], c0[31:0]};
    last_i  = lst;
    valid_i = 1'b1;
  endtask

  // One accepted beat with ready_i high; outputs checked one cycle later.
  task automatic send(input string tag, input int c0, input int c1, input logic lst,
                      input logic ecls, input logic ewk);
    drive(c0, c1, lst);
    @(posedge clk_i); #1;
    chk({tag, "_valid"}, valid_o, 1);
    chk({tag, "_class"}, class_o, ecls);
    chk({tag, "_wake"},  wake_o,  ewk);
    chk({tag, "_last"},  last_o,  lst);
  endtask

  task automatic idle(input string tag);
    valid_i = 1'b0;
    last_i  = 1'b0;
    @(posedge clk_i); #1;
    chk({tag, "_idle_valid"}, valid_o, 0);
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    last_i  = 1'b0;
    rst_n_i = 1'b0;
    #1;
    chk("rst_valid", valid_o, 0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
  endtask

  initial begin
    rst_n_i = 1'b0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;
    #2;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_ready_o", ready_o, 1);
    chk("rst_class_o", class_o, 0);
    chk("rst_wake_o",  wake_o,  0);
    chk("rst_last_o",  last_o,  0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    ready_i = 1'b1;

    // Three wake beats: fire on the third.
    chk("v1_pre_valid", valid_o, 0);
    send("v1a", 5, 9, 0, 1, 0);
    send("v1b", 5, 9, 0, 1, 0);
    send("v1c", 5, 9, 0, 1, 1);
    // Two holdoff beats, then a single fresh vote.
    send("v2a", 5, 9, 0, 1, 0);
    send("v2b", 5, 9, 0, 1, 0);
    send("v2c", 5, 9, 0, 1, 0);
    idle("v2");

    // Argmax: tie and signed compare.
    do_reset();
    send("v3tie", -3, -3, 0, 0, 0);
    send("v3sgn", -8, -2, 0, 1, 0);
    send("v3neg", -1, -100, 0, 0, 0);
    idle("v3");

    // last_i clears the vote state after its own decision.
    do_reset();
    send("v4a", 5, 9, 0, 1, 0);
    send("v4b", 5, 9, 1, 1, 0);
    send("v4c", 5, 9, 0, 1, 0);
    send("v4d", 5, 9, 0, 1, 0);
    send("v4e", 5, 9, 0, 1, 1);
    idle("v4");

    // Backpressure: outputs freeze, then stream without bubbles.
    do_reset();
    out0 = n_out;
    ready_i = 1'b0;
    drive(5, 9, 0);
    @(posedge clk_i); #1;
    chk("v5a_valid", valid_o, 1);
    chk("v5a_class", class_o, 1);
    drive(9, 5, 0);
    for (int i = 0; i < 3; i++) begin
      chk("v5_ready_low", ready_o, 0);
      @(posedge clk_i); #1;
      chk("v5_frozen_valid", valid_o, 1);
      chk("v5_frozen_class", class_o, 1);
      chk("v5_frozen_wake",  wake_o,  0);
    end
    ready_i = 1'b1;
    #1;
    chk("v6_ready_high", ready_o, 1);
    @(posedge clk_i); #1;
    chk("v6b_valid", valid_o, 1);
    chk("v6b_class", class_o, 0);
    drive(1, 2, 0);
    @(posedge clk_i); #1;
    chk("v6c_valid", valid_o, 1);
    chk("v6c_class", class_o, 1);
    chk("v6c_wake",  wake_o,  0);
    idle("v6");
    chk("v6_out_count", n_out - out0, 3);

    // Reset mid-stream discards the pending beat and the two votes.
    do_reset();
    send("v7a", 5, 9, 0, 1, 0);
    send("v7b", 5, 9, 0, 1, 0);
    valid_i = 1'b0;
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("v7_async_valid", valid_o, 0);
    chk("v7_async_ready", ready_o, 1);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    send("v7c", 5, 9, 0, 1, 0);
    send("v7d", 5, 9, 0, 1, 0);
    send("v7e", 5, 9, 0, 1, 1);
    idle("v7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
